lcd_text_stream_adapter: RTL and testbench



---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_cursor_tracker.sv | 131 +++++++++++++
 rtl/lcd_text_stream_adapter.sv | 177 +++++++++++++++++
 tb/tb_lcd_text_stream_adapter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and DDRAM address helper for the
// HD44780 text stream adapter.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [6:0] LCD_ROW1_BASE     = 7'h40;

  localparam logic [7:0] CHAR_LF            = 8'h0A;
  localparam logic [7:0] CHAR_CR            = 8'h0D;
  localparam logic [7:0] CHAR_FF            = 8'h0C;
  localparam logic [7:0] CHAR_PRINTABLE_MIN = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_ADDR = 2'd1,
    ST_SEND_CHAR = 2'd2,
    ST_SEND_CLR  = 2'd3
  } lcd_adapt_state_t;

  // Rows 2 and 3 continue the row 0 / row 1 DDRAM lines after COLS cells.
  function automatic logic [6:0] lcd_ddram_addr(input logic [1:0] row,
                                                input logic [5:0] col,
                                                input logic [6:0] cols);
    logic [6:0] base;
    case (row)
      2'd0:    base = 7'h00;
      2'd1:    base = LCD_ROW1_BASE;
      2'd2:    base = cols;
      default: base = LCD_ROW1_BASE + cols;
    endcase
    return base + {1'b0, col};
  endfunction

endpackage

// File: rtl/lcd_cursor_tracker.sv
// Cursor row/column tracking for a COLS x ROWS character display.
// Owns the wrap logic, the just_wrapped LF-absorb flag, the addr_dirty flag
// and the DDRAM address of the current cursor position.
// Optional feature macro: LCD_CLEAR_ON_WRAP_EN (request a clear whenever the
// cursor moves from the last row back to row 0).
module lcd_cursor_tracker
  import lcd_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 2
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       ev_accept,
  input  logic       ev_home,
  input  logic       ev_cr,
  input  logic       ev_lf,
  input  logic       ev_addr_done,
  input  logic       ev_char_done,
  output logic [1:0] cur_row,
  output logic [5:0] cur_col,
  output logic       addr_dirty,
  output logic       clear_pending,
  output logic [6:0] ddram_addr
);

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  logic [1:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic       dirty_q, dirty_d;
  logic       jw_q, jw_d;
  logic [1:0] next_row;
  logic       wrap_to_top;

  // Next-state cursor update from the adapter's event strobes.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    dirty_d     = dirty_q;
    jw_d        = jw_q;
    next_row    = (row_q == LAST_ROW) ? 2'd0 : row_q + 2'd1;
    wrap_to_top = 1'b0;

    if (ev_accept) begin
      jw_d = 1'b0;
    end
    if (ev_home) begin
      row_d   = 2'd0;
      col_d   = 6'd0;
      dirty_d = 1'b0;
    end
    if (ev_cr) begin
      col_d   = 6'd0;
      dirty_d = 1'b1;
    end
    if (ev_lf && !jw_q) begin
      row_d       = next_row;
      col_d       = 6'd0;
      dirty_d     = 1'b1;
      wrap_to_top = (row_q == LAST_ROW);
    end
    if (ev_addr_done) begin
      dirty_d = 1'b0;
    end
    if (ev_char_done) begin
      if (col_q == LAST_COL) begin
        col_d       = 6'd0;
        row_d       = next_row;
        dirty_d     = 1'b1;
        jw_d        = 1'b1;
        wrap_to_top = (row_q == LAST_ROW);
      end else begin
        col_d = col_q + 6'd1;
        jw_d  = 1'b0;
      end
    end
  end

  // Cursor state registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      row_q   <= 2'd0;
      col_q   <= 6'd0;
      dirty_q <= 1'b0;
      jw_q    <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      dirty_q <= dirty_d;
      jw_q    <= jw_d;
    end
  end

`ifdef LCD_CLEAR_ON_WRAP_EN
  logic cp_q, cp_d;

  // Remember a return to row 0 until the next clear has been issued.
  always_comb begin
    cp_d = cp_q;
    if (ev_home) begin
      cp_d = 1'b0;
    end
    if (wrap_to_top) begin
      cp_d = 1'b1;
    end
  end

  // Clear-request register.
  always_ff @(posedge clk) begin
    if (srst) begin
      cp_q <= 1'b0;
    end else begin
      cp_q <= cp_d;
    end
  end

  assign clear_pending = cp_q;
`else
  logic unused_wrap;
  assign unused_wrap   = wrap_to_top;
  assign clear_pending = 1'b0;
`endif

  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign addr_dirty = dirty_q;
  assign ddram_addr = lcd_ddram_addr(row_q, col_q, 7'(COLS));

endmodule

// File: rtl/lcd_text_stream_adapter.sv
// Byte-stream to HD44780 host-interface adapter. Decodes text and control
// codes, inserts set-DDRAM-address commands after wraps/newlines, and drives
// registered host_valid/host_rs/host_data with a valid/ready handshake.
// Optional feature macro: LCD_CLEAR_ON_WRAP_EN (clear display before the
// first character printed after the cursor returns to row 0).
module lcd_text_stream_adapter
  import lcd_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 2
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       init_done,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       host_valid,
  output logic       host_rs,
  output logic [7:0] host_data,
  input  logic       host_ready,
  output logic [1:0] cur_row,
  output logic [5:0] cur_col
);

  lcd_adapt_state_t state_q, state_d;
  logic       host_valid_q, host_valid_d;
  logic       host_rs_q, host_rs_d;
  logic [7:0] host_data_q, host_data_d;
  logic [7:0] char_q, char_d;
  logic       clr_then_char_q, clr_then_char_d;

  logic       accept;
  logic       handshake;
  logic       ev_accept, ev_home, ev_cr, ev_lf, ev_addr_done, ev_char_done;
  logic       addr_dirty;
  logic       clear_pending;
  logic [6:0] ddram_addr;

  assign s_ready   = (state_q == ST_IDLE) && init_done && !srst;
  assign accept    = s_valid && s_ready;
  assign handshake = host_valid_q && host_ready;

  lcd_cursor_tracker #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk          (clk),
    .srst         (srst),
    .ev_accept    (ev_accept),
    .ev_home      (ev_home),
    .ev_cr        (ev_cr),
    .ev_lf        (ev_lf),
    .ev_addr_done (ev_addr_done),
    .ev_char_done (ev_char_done),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .addr_dirty   (addr_dirty),
    .clear_pending(clear_pending),
    .ddram_addr   (ddram_addr)
  );

  // Byte decode, transaction sequencing and next registered host outputs.
  always_comb begin
    state_d         = state_q;
    host_valid_d    = host_valid_q;
    host_rs_d       = host_rs_q;
    host_data_d     = host_data_q;
    char_d          = char_q;
    clr_then_char_d = clr_then_char_q;
    ev_accept       = 1'b0;
    ev_home         = 1'b0;
    ev_cr           = 1'b0;
    ev_lf           = 1'b0;
    ev_addr_done    = 1'b0;
    ev_char_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (s_data == CHAR_FF) begin
            ev_accept       = 1'b1;
            state_d         = ST_SEND_CLR;
            host_valid_d    = 1'b1;
            host_rs_d       = 1'b0;
            host_data_d     = LCD_CMD_CLEAR;
            clr_then_char_d = 1'b0;
          end else if (s_data == CHAR_CR) begin
            ev_accept = 1'b1;
            ev_cr     = 1'b1;
          end else if (s_data == CHAR_LF) begin
            ev_accept = 1'b1;
            ev_lf     = 1'b1;
          end else if (s_data >= CHAR_PRINTABLE_MIN) begin
            ev_accept    = 1'b1;
            char_d       = s_data;
            host_valid_d = 1'b1;
            if (clear_pending) begin
              state_d         = ST_SEND_CLR;
              host_rs_d       = 1'b0;
              host_data_d     = LCD_CMD_CLEAR;
              clr_then_char_d = 1'b1;
            end else if (addr_dirty) begin
              state_d     = ST_SEND_ADDR;
              host_rs_d   = 1'b0;
              host_data_d = LCD_CMD_SET_DDRAM | {1'b0, ddram_addr};
            end else begin
              state_d     = ST_SEND_CHAR;
              host_rs_d   = 1'b1;
              host_data_d = s_data;
            end
          end
        end
      end

      ST_SEND_ADDR: begin
        if (handshake) begin
          ev_addr_done = 1'b1;
          state_d      = ST_SEND_CHAR;
          host_rs_d    = 1'b1;
          host_data_d  = char_q;
        end
      end

      ST_SEND_CHAR: begin
        if (handshake) begin
          ev_char_done = 1'b1;
          state_d      = ST_IDLE;
          host_valid_d = 1'b0;
        end
      end

      ST_SEND_CLR: begin
        if (handshake) begin
          ev_home = 1'b1;
          if (clr_then_char_q) begin
            state_d     = ST_SEND_CHAR;
            host_rs_d   = 1'b1;
            host_data_d = char_q;
          end else begin
            state_d      = ST_IDLE;
            host_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        host_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered host interface.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q         <= ST_IDLE;
      host_valid_q    <= 1'b0;
      host_rs_q       <= 1'b0;
      host_data_q     <= 8'h00;
      char_q          <= 8'h00;
      clr_then_char_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      host_valid_q    <= host_valid_d;
      host_rs_q       <= host_rs_d;
      host_data_q     <= host_data_d;
      char_q          <= char_d;
      clr_then_char_q <= clr_then_char_d;
    end
  end

  assign host_valid = host_valid_q;
  assign host_rs    = host_rs_q;
  assign host_data  = host_data_q;

endmodule

// File: tb/tb_lcd_text_stream_adapter.sv
// Self-checking bench for lcd_text_stream_adapter (COLS=16, ROWS=2).
// A table of {byte, expected LCD transactions, expected cursor} records is
// applied in order, plus hand-written reset, back-pressure, init_done and
// mid-transaction reset sequences. Expectations follow the clear-on-wrap
// variant when LCD_CLEAR_ON_WRAP_EN is defined.
module tb_lcd_text_stream_adapter;

  logic       clk = 1'b0;
  logic       srst;
  logic       init_done;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       host_valid;
  logic       host_rs;
  logic [7:0] host_data;
  logic       host_ready = 1'b0;
  logic [1:0] cur_row;
  logic [5:0] cur_col;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [7:0] inByte;
    int         nTxn;
    logic [8:0] txn0;
    logic [8:0] txn1;
    logic [1:0] row;
    logic [5:0] col;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] txnQ[$];
  int         readyDelay = 0;
  int         waitCnt    = 0;

  always #5 clk = ~clk;

  lcd_text_stream_adapter #(
    .COLS(16),
    .ROWS(2)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .init_done (init_done),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .host_valid(host_valid),
    .host_rs   (host_rs),
    .host_data (host_data),
    .host_ready(host_ready),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  // LCD controller model: accepts each transaction after readyDelay
  // falling edges and logs it as {rs, data}.
  always @(negedge clk) begin
    if (host_ready) begin
      host_ready = 1'b0;
      waitCnt    = 0;
    end else if (host_valid && !srst) begin
      if (waitCnt >= readyDelay) begin
        txnQ.push_back({host_rs, host_data});
        host_ready = 1'b1;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  function automatic logic [8:0] dTx(input logic [7:0] b);
    return {1'b1, b};
  endfunction

  function automatic logic [8:0] cTx(input logic [7:0] b);
    return {1'b0, b};
  endfunction

  function automatic vec_t mk(input logic [7:0] b, input int n,
                              input logic [8:0] t0, input logic [8:0] t1,
                              input logic [1:0] r, input logic [5:0] c);
    vec_t v;
    v.inByte = b;
    v.nTxn   = n;
    v.txn0   = t0;
    v.txn1   = t1;
    v.row    = r;
    v.col    = c;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: timed out, got no response, expected completion", name);
  endtask

  // Present one byte and hold it until the adapter takes it.
  task automatic sendByte(input logic [7:0] b);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      failTimeout("accept");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Wait until the adapter is back in idle with no transaction pending.
  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(s_ready && !host_valid) && n < 100);
    if (!(s_ready && !host_valid)) begin
      failTimeout("idle");
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sendByte(v.inByte);
    waitIdle();
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    logic [8:0] got;
    checkOutput($sformatf("v%0d_ntxn", idx), txnQ.size(), v.nTxn);
    for (int k = 0; k < 2; k++) begin
      if (k < v.nTxn) begin
        got = (txnQ.size() > 0) ? txnQ.pop_front() : 9'h1FF;
        checkOutput($sformatf("v%0d_txn%0d", idx, k), got,
                    (k == 0) ? v.txn0 : v.txn1);
      end
    end
    txnQ.delete();
    checkOutput($sformatf("v%0d_row", idx), cur_row, v.row);
    checkOutput($sformatf("v%0d_col", idx), cur_col, v.col);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    // Reset with init_done low and a byte already offered.
    srst       = 1'b1;
    init_done  = 1'b0;
    s_valid    = 1'b1;
    s_data     = 8'h41;
    readyDelay = 5;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_host_valid", host_valid, 0);
    checkOutput("rst_host_rs", host_rs, 0);
    checkOutput("rst_host_data", host_data, 0);
    checkOutput("rst_row", cur_row, 0);
    checkOutput("rst_col", cur_col, 0);

    srst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("noinit_s_ready", s_ready, 0);
    checkOutput("noinit_host_valid", host_valid, 0);

    init_done = 1'b1;
    #1;
    checkOutput("init_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checkOutput("first_host_valid", host_valid, 1);
    checkOutput("first_host_rs", host_rs, 1);
    checkOutput("first_host_data", host_data, 8'h41);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("hold%0d_valid", k), host_valid, 1);
      checkOutput($sformatf("hold%0d_rs", k), host_rs, 1);
      checkOutput($sformatf("hold%0d_data", k), host_data, 8'h41);
    end
    waitIdle();
    readyDelay = 0;
    checkVec(0, mk(8'h41, 1, dTx(8'h41), 9'h0, 2'd0, 6'd1));

    // Directed table, starting at cursor (0,1).
    vecs.push_back(mk(8'h0C, 1, cTx(8'h01), 9'h0, 2'd0, 6'd0));
    vecs.push_back(mk(8'h58, 1, dTx(8'h58), 9'h0, 2'd0, 6'd1));
    vecs.push_back(mk(8'h59, 1, dTx(8'h59), 9'h0, 2'd0, 6'd2));
    vecs.push_back(mk(8'h0D, 0, 9'h0, 9'h0, 2'd0, 6'd0));
    vecs.push_back(mk(8'h5A, 2, cTx(8'h80), dTx(8'h5A), 2'd0, 6'd1));
    vecs.push_back(mk(8'h01, 0, 9'h0, 9'h0, 2'd0, 6'd1));
    vecs.push_back(mk(8'h0A, 0, 9'h0, 9'h0, 2'd1, 6'd0));
    vecs.push_back(mk(8'h61, 2, cTx(8'hC0), dTx(8'h61), 2'd1, 6'd1));
    vecs.push_back(mk(8'h0C, 1, cTx(8'h01), 9'h0, 2'd0, 6'd0));
    vecs.push_back(mk(8'hFF, 1, dTx(8'hFF), 9'h0, 2'd0, 6'd1));
    vecs.push_back(mk(8'h0A, 0, 9'h0, 9'h0, 2'd1, 6'd0));
    vecs.push_back(mk(8'h0A, 0, 9'h0, 9'h0, 2'd0, 6'd0));
`ifdef LCD_CLEAR_ON_WRAP_EN
    vecs.push_back(mk(8'h20, 2, cTx(8'h01), dTx(8'h20), 2'd0, 6'd1));
`else
    vecs.push_back(mk(8'h20, 2, cTx(8'h80), dTx(8'h20), 2'd0, 6'd1));
`endif
    // 17 characters: wrap after the 16th inserts a row-1 address.
    vecs.push_back(mk(8'h0C, 1, cTx(8'h01), 9'h0, 2'd0, 6'd0));
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(8'(8'h30 + i), 1, dTx(8'(8'h30 + i)), 9'h0,
                        (i == 15) ? 2'd1 : 2'd0,
                        (i == 15) ? 6'd0 : 6'(i + 1)));
    end
    vecs.push_back(mk(8'h40, 2, cTx(8'hC0), dTx(8'h40), 2'd1, 6'd1));
    // 16 characters then LF: LF right after a wrap is absorbed.
    vecs.push_back(mk(8'h0C, 1, cTx(8'h01), 9'h0, 2'd0, 6'd0));
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(8'(8'h41 + i), 1, dTx(8'(8'h41 + i)), 9'h0,
                        (i == 15) ? 2'd1 : 2'd0,
                        (i == 15) ? 6'd0 : 6'(i + 1)));
    end
    vecs.push_back(mk(8'h0A, 0, 9'h0, 9'h0, 2'd1, 6'd0));
    vecs.push_back(mk(8'h42, 2, cTx(8'hC0), dTx(8'h42), 2'd1, 6'd1));
    // Finish row 1: wrap back to row 0 (33rd character overall).
    for (int i = 0; i < 15; i++) begin
      vecs.push_back(mk(8'(8'h61 + i), 1, dTx(8'(8'h61 + i)), 9'h0,
                        (i == 14) ? 2'd0 : 2'd1,
                        (i == 14) ? 6'd0 : 6'(i + 2)));
    end
`ifdef LCD_CLEAR_ON_WRAP_EN
    vecs.push_back(mk(8'h21, 2, cTx(8'h01), dTx(8'h21), 2'd0, 6'd1));
`else
    vecs.push_back(mk(8'h21, 2, cTx(8'h80), dTx(8'h21), 2'd0, 6'd1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVec(i + 1, vecs[i]);
    end

    // init_done low in idle blocks acceptance.
    init_done = 1'b0;
    s_valid   = 1'b1;
    s_data    = 8'h45;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("blocked_s_ready", s_ready, 0);
    end
    s_valid   = 1'b0;
    init_done = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("blocked_txns", txnQ.size(), 0);
    checkOutput("blocked_col", cur_col, 1);

    // Reset while a transaction waits for host_ready.
    readyDelay = 1000;
    sendByte(8'h51);
    @(negedge clk);
    #1;
    checkOutput("pre_rst_valid", host_valid, 1);
    checkOutput("pre_rst_data", host_data, 8'h51);
    srst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", host_valid, 0);
    checkOutput("mid_rst_row", cur_row, 0);
    checkOutput("mid_rst_col", cur_col, 0);
    @(negedge clk);
    srst       = 1'b0;
    readyDelay = 0;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_txns", txnQ.size(), 0);
    txnQ.delete();
    v = mk(8'h52, 1, dTx(8'h52), 9'h0, 2'd0, 6'd1);
    applyStimulus(v);
    checkVec(99, v);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
